compuertas_autotest: RTL and testbench
======================================

# compuertas_autotest

Self-test sequencer for the two-input logic-gate unit. On `start`, it drives the gate unit's `e0`/`e1` inputs through all four input combinations and waits a programmable settle time on each. It then samples the eight gate outputs (AND, OR, XOR, NAND, NOR, XNOR, NOT, YES) and checks them against a fixed golden truth table. It reports pass/fail, a per-output failure mask and the first failing vector, and sits between the board-level control logic and the gate unit.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1..255.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `start` in 1: run request; sampled only in IDLE.
- `e0_o` in/out: out 1, drives gate-unit input `e0`; registered.
- `e1_o` out 1: drives gate-unit input `e1`; registered.
- `s_i` in 8: gate-unit outputs, bit n = `sn` (s0 AND … s7 YES).
- `busy` out 1: high in DRIVE and SAMPLE.
- `done` out 1: one-cycle pulse when a run completes.
- `pass` out 1: last run had zero mismatches; valid from `done` and held.
- `fail_mask` out 8: OR over all vectors of (`s_i` XOR golden); held.
- `first_fail_vec` out 2: index of the first vector with any mismatch; held.
- `fail_valid` out 1: at least one mismatch in the last run; held.
- `run_count` out 8: completed runs, saturating at 255.

## Operation
- Vector index `idx` is a 2-bit value; `e0_o` = `idx[0]`, `e1_o` = `idx[1]`.
- Golden `s_i` (s7..s0) by idx:
  - idx 0 → 8'h78
  - idx 1 → 8'h8E
  - idx 2 → 8'h4E
  - idx 3 → 8'hA3
- States and transitions:
  - IDLE: waits for `start`=1. On start, clears `fail_mask`, `fail_valid`, `first_fail_vec` and `pass`, sets `idx`=0 and moves to DRIVE.
  - DRIVE: outputs `e0_o`/`e1_o` from `idx`. A settle counter counts 1..SETTLE_CYCLES; on reaching SETTLE_CYCLES the block moves to SAMPLE.
  - SAMPLE (1 cycle): mismatch = `s_i` ^ golden[idx]; OR it into `fail_mask`.
    - If mismatch ≠ 0 and `fail_valid`=0: latch `first_fail_vec`=idx and set `fail_valid`.
    - If idx=3: go to DONE.
    - Otherwise: idx+1 and return to DRIVE; the settle counter restarts.
  - DONE (1 cycle): `done`=1, `pass`=~`fail_valid` using the final accumulated value including the idx-3 sample, `run_count`+1 saturating. Then go to IDLE.
- `e0_o`/`e1_o` = 0 in IDLE and DONE.
- `start` in any state other than IDLE is ignored and not queued. `start` held high re-launches a run from IDLE on the cycle after DONE.
- Results (`pass`, `fail_mask`, `first_fail_vec`, `fail_valid`) hold until the next accepted start.
- Reset values: state IDLE; `idx`, `e0_o`, `e1_o`, `busy`, `done`, `pass`, `fail_mask`, `first_fail_vec`, `fail_valid` and `run_count` all 0.
- Reset asserted mid-run aborts the run at that edge. The block returns to the reset values above with no `done` pulse, and `run_count` is unchanged from 0.

## Timing
- `start` is accepted at edge k. `busy` and vector 0 are driven from cycle k+1.
- Each vector occupies SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in DRIVE, 1 in SAMPLE.
- `done` is high in cycle k+1+4·(SETTLE_CYCLES+1); for the default, k+13. `busy` is low in that cycle.
- `s_i` is used only in SAMPLE and must be stable there. The gate unit is combinational, so SETTLE_CYCLES ≥ 1 guarantees this.
- Minimum start-to-start period: 4·(SETTLE_CYCLES+1)+2 cycles.

## Structure
- Shared package `compuertas_pkg` holds:
  - the state enum (IDLE, DRIVE, SAMPLE, DONE);
  - `GOLDEN[0:3]` = {8'h78, 8'h8E, 8'h4E, 8'hA3};
  - gate-output bit-position constants (AND=0 … YES=7).
- The gate unit is instantiated outside this block.
- One natural sub-module: `compuertas_settle_cnt`, an 8-bit load/count/terminal-flag counter used for the DRIVE settle time.

## Test plan
- Correct gate unit in loop, SETTLE_CYCLES=2, `start` pulse at cycle 10 → `done` at cycle 23, `pass`=1, `fail_mask`=8'h00, `fail_valid`=0, `run_count`=1.
- `s_i` bit 2 (XOR) forced to 0 → `pass`=0, `fail_mask`=8'h04, `fail_valid`=1, `first_fail_vec`=1.
- `s_i` forced to 8'hFF on idx 3 only → `fail_mask`=8'h5C, `first_fail_vec`=3, `pass`=0.
- `start` re-pulsed while `busy` → ignored; a single `done` pulse at the original cycle, and `run_count` increments by 1 only.
- `rst` asserted during DRIVE of idx 2 → next cycle: IDLE, all outputs 0, no `done` pulse; the next `start` completes normally with `pass`=1.
- `start` held high for 300 runs → `run_count` saturates at 255, with a `done` pulse every 14 cycles.

Source files
------------

// File: rtl/compuertas_pkg.sv
// Shared types and constants for the logic-gate self-test sequencer:
// state encoding, golden truth table and gate-output bit positions.
package compuertas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } autotestState_t;

    // Expected {YES,NOT,XNOR,NOR,NAND,XOR,OR,AND} for idx = {e1,e0}
    localparam logic [7:0] GOLDEN [0:3] = '{8'h78, 8'h8E, 8'h4E, 8'hA3};

    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_XOR  = 2;
    localparam int GATE_NAND = 3;
    localparam int GATE_NOR  = 4;
    localparam int GATE_XNOR = 5;
    localparam int GATE_NOT  = 6;
    localparam int GATE_YES  = 7;

    localparam logic [1:0] LAST_IDX = 2'd3;

    function automatic logic [7:0] goldenFor(input logic [1:0] idx);
        return GOLDEN[idx];
    endfunction

endpackage

// File: rtl/compuertas_autotest_if.sv
// Bus between the board-level controller, the self-test sequencer and
// the gate unit: run control, gate drive/sense and test results.
interface compuertas_autotest_if;

    logic       start;
    logic       e0_o;
    logic       e1_o;
    logic [7:0] s_i;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] fail_mask;
    logic [1:0] first_fail_vec;
    logic       fail_valid;
    logic [7:0] run_count;

    // Controller / gate-unit side
    modport master (
        output start,
        output s_i,
        input  e0_o,
        input  e1_o,
        input  busy,
        input  done,
        input  pass,
        input  fail_mask,
        input  first_fail_vec,
        input  fail_valid,
        input  run_count
    );

    // Sequencer side
    modport slave (
        input  start,
        input  s_i,
        output e0_o,
        output e1_o,
        output busy,
        output done,
        output pass,
        output fail_mask,
        output first_fail_vec,
        output fail_valid,
        output run_count
    );

endinterface

// File: rtl/compuertas_settle_cnt.sv
// Settle-time counter: a load starts the count at 1, enable advances it
// and it parks on the limit, where the terminal flag is raised.
module compuertas_settle_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_en,
    input  logic [7:0] i_limit,
    output logic [7:0] o_count,
    output logic       o_term
);

    logic [7:0] r_count;
    logic       w_term;

    assign w_term  = (r_count == i_limit);
    assign o_term  = w_term;
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= 8'd1;
        end else if (i_en && !w_term) begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: rtl/compuertas_autotest.sv
// Self-test sequencer: walks the gate unit through all four input vectors,
// compares each sampled output byte with the golden table and reports results.
module compuertas_autotest
    import compuertas_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    compuertas_autotest_if.slave  bus
);

    localparam logic [7:0] W_LIMIT = 8'(SETTLE_CYCLES);

    autotestState_t r_state;
    logic [1:0]     r_idx;
    logic           r_e0;
    logic           r_e1;
    logic           r_busy;
    logic           r_done;
    logic           r_pass;
    logic [7:0]     r_failMask;
    logic [1:0]     r_firstFailVec;
    logic           r_failValid;
    logic [7:0]     r_runCount;

    logic [7:0] w_mismatch;
    logic       w_anyMiss;
    logic [1:0] w_nextIdx;
    logic       w_cntLoad;
    logic       w_cntEn;
    logic       w_settled;
    logic [7:0] w_cntValue;

    assign w_mismatch = bus.s_i ^ goldenFor(r_idx);
    assign w_anyMiss  = |w_mismatch;
    assign w_nextIdx  = r_idx + 2'd1;

    // Counter restarts whenever a new vector enters DRIVE
    assign w_cntLoad = ((r_state == ST_IDLE) && bus.start) ||
                       ((r_state == ST_SAMPLE) && (r_idx != LAST_IDX));
    assign w_cntEn   = (r_state == ST_DRIVE);

    compuertas_settle_cnt u_settle (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_cntLoad),
        .i_en    (w_cntEn),
        .i_limit (W_LIMIT),
        .o_count (w_cntValue),
        .o_term  (w_settled)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_idx          <= 2'd0;
            r_e0           <= 1'b0;
            r_e1           <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_failMask     <= 8'd0;
            r_firstFailVec <= 2'd0;
            r_failValid    <= 1'b0;
            r_runCount     <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_failMask     <= 8'd0;
                        r_failValid    <= 1'b0;
                        r_firstFailVec <= 2'd0;
                        r_pass         <= 1'b0;
                        r_idx          <= 2'd0;
                        r_e0           <= 1'b0;
                        r_e1           <= 1'b0;
                        r_busy         <= 1'b1;
                        r_state        <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (w_settled) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_failMask <= r_failMask | w_mismatch;
                    if (w_anyMiss && !r_failValid) begin
                        r_firstFailVec <= r_idx;
                        r_failValid    <= 1'b1;
                    end
                    // pass must already include the last vector's mismatch when done rises
                    if (r_idx == LAST_IDX) begin
                        r_pass  <= !(r_failValid || w_anyMiss);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_e0    <= 1'b0;
                        r_e1    <= 1'b0;
                        r_state <= ST_DONE;
                        if (r_runCount != 8'hFF) begin
                            r_runCount <= r_runCount + 8'd1;
                        end
                    end else begin
                        r_idx   <= w_nextIdx;
                        r_e0    <= w_nextIdx[0];
                        r_e1    <= w_nextIdx[1];
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.e0_o           = r_e0;
    assign bus.e1_o           = r_e1;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_pass;
    assign bus.fail_mask      = r_failMask;
    assign bus.first_fail_vec = r_firstFailVec;
    assign bus.fail_valid     = r_failValid;
    assign bus.run_count      = r_runCount;

    logic w_unusedCnt;
    assign w_unusedCnt = ^w_cntValue;

endmodule

// File: tb/tb_compuertas_autotest.sv
// Directed bench for compuertas_autotest with a behavioural gate unit in the
// loop and fault injection on its outputs.
module tb_compuertas_autotest;

    logic clk;
    logic rst;

    compuertas_autotest_if bus ();

    compuertas_autotest #(.SETTLE_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int testsRun;
    int testsFailed;

    logic [7:0] clrMask;
    logic [7:0] setMask;
    logic       idx3Ff;
    logic [7:0] gates;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gate unit with stuck-at fault injection
    always_comb begin
        gates = {bus.e0_o, ~bus.e0_o, ~(bus.e0_o ^ bus.e1_o), ~(bus.e0_o | bus.e1_o),
                 ~(bus.e0_o & bus.e1_o), bus.e0_o ^ bus.e1_o, bus.e0_o | bus.e1_o,
                 bus.e0_o & bus.e1_o};
        bus.s_i = (gates & ~clrMask) | setMask;
        if (idx3Ff && bus.e0_o && bus.e1_o) begin
            bus.s_i = 8'hFF;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulses start, then watches up to 30 cycles; offsets count from the accept edge
    task automatic launchAndWatch(output int doneAt, output int doneCount,
                                  output logic busyFirst, output logic busyAtDone);
        doneAt     = -1;
        doneCount  = 0;
        busyFirst  = 1'b0;
        busyAtDone = 1'b1;
        bus.start  = 1'b1;
        step(1);
        bus.start  = 1'b0;
        busyFirst  = bus.busy;
        for (int off = 1; off <= 30; off++) begin
            if (bus.done) begin
                doneCount++;
                if (doneAt < 0) begin
                    doneAt     = off;
                    busyAtDone = bus.busy;
                end
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        testsRun++;
        if ({bus.e0_o, bus.e1_o, bus.busy, bus.done, bus.pass, bus.fail_valid} !== 6'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_flags: got %b want 000000",
                     {bus.e0_o, bus.e1_o, bus.busy, bus.done, bus.pass, bus.fail_valid});
        end
        testsRun++;
        if ({bus.fail_mask, bus.first_fail_vec, bus.run_count} !== 18'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_results: mask=%h first=%0d runs=%0d want all 0",
                     bus.fail_mask, bus.first_fail_vec, bus.run_count);
        end
    endtask

    task automatic test_pass_run();
        int doneAt, doneCount;
        logic busyFirst, busyAtDone;
        step(7);
        launchAndWatch(doneAt, doneCount, busyFirst, busyAtDone);
        testsRun++;
        if (doneAt !== 13 || doneCount !== 1) begin
            testsFailed++;
            $display("[TB] FAIL pass_done_timing: at=%0d count=%0d want at=13 count=1", doneAt, doneCount);
        end
        testsRun++;
        if (busyFirst !== 1'b1 || busyAtDone !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL pass_busy: first=%b atDone=%b want 1/0", busyFirst, busyAtDone);
        end
        testsRun++;
        if ({bus.pass, bus.fail_valid, bus.fail_mask} !== {1'b1, 1'b0, 8'h00}) begin
            testsFailed++;
            $display("[TB] FAIL pass_results: pass=%b valid=%b mask=%h want 1/0/00",
                     bus.pass, bus.fail_valid, bus.fail_mask);
        end
        testsRun++;
        if (bus.run_count !== 8'd1) begin
            testsFailed++;
            $display("[TB] FAIL pass_run_count: got %0d want 1", bus.run_count);
        end
    endtask

    task automatic test_vector_drive();
        // idx1 DRIVE occupies offsets 4..5, idx3 DRIVE offsets 10..11
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(3);
        testsRun++;
        if ({bus.e1_o, bus.e0_o} !== 2'b01) begin
            testsFailed++;
            $display("[TB] FAIL drive_idx1: e1e0=%b want 01", {bus.e1_o, bus.e0_o});
        end
        step(6);
        testsRun++;
        if ({bus.e1_o, bus.e0_o} !== 2'b11) begin
            testsFailed++;
            $display("[TB] FAIL drive_idx3: e1e0=%b want 11", {bus.e1_o, bus.e0_o});
        end
        step(3);
        testsRun++;
        if ({bus.done, bus.e1_o, bus.e0_o} !== 3'b100) begin
            testsFailed++;
            $display("[TB] FAIL drive_done_zero: done,e1,e0=%b want 100", {bus.done, bus.e1_o, bus.e0_o});
        end
        step(2);
    endtask

    task automatic test_xor_fault();
        int doneAt, doneCount;
        logic busyFirst, busyAtDone;
        clrMask = 8'h04;
        launchAndWatch(doneAt, doneCount, busyFirst, busyAtDone);
        clrMask = 8'h00;
        testsRun++;
        if ({bus.pass, bus.fail_valid, bus.fail_mask, bus.first_fail_vec} !== {1'b0, 1'b1, 8'h04, 2'd1}) begin
            testsFailed++;
            $display("[TB] FAIL xor_fault: pass=%b valid=%b mask=%h first=%0d want 0/1/04/1",
                     bus.pass, bus.fail_valid, bus.fail_mask, bus.first_fail_vec);
        end
        testsRun++;
        if (bus.run_count !== 8'd3 || doneAt !== 13) begin
            testsFailed++;
            $display("[TB] FAIL xor_run_count: runs=%0d at=%0d want 3/13", bus.run_count, doneAt);
        end
    endtask

    task automatic test_idx3_fault();
        int doneAt, doneCount;
        logic busyFirst, busyAtDone;
        idx3Ff = 1'b1;
        launchAndWatch(doneAt, doneCount, busyFirst, busyAtDone);
        idx3Ff = 1'b0;
        testsRun++;
        if ({bus.pass, bus.fail_valid, bus.fail_mask, bus.first_fail_vec} !== {1'b0, 1'b1, 8'h5C, 2'd3}) begin
            testsFailed++;
            $display("[TB] FAIL idx3_fault: pass=%b valid=%b mask=%h first=%0d want 0/1/5c/3",
                     bus.pass, bus.fail_valid, bus.fail_mask, bus.first_fail_vec);
        end
    endtask

    task automatic test_start_while_busy();
        int doneAt, doneCount;
        doneAt    = -1;
        doneCount = 0;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        for (int off = 1; off <= 30; off++) begin
            bus.start = (off == 5 || off == 9 || off == 13);
            if (bus.done) begin
                doneCount++;
                if (doneAt < 0) doneAt = off;
            end
            step(1);
        end
        bus.start = 1'b0;
        testsRun++;
        if (doneAt !== 13 || doneCount !== 1) begin
            testsFailed++;
            $display("[TB] FAIL busy_start_ignored: at=%0d count=%0d want 13/1", doneAt, doneCount);
        end
        testsRun++;
        if (bus.run_count !== 8'd5 || bus.pass !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL busy_run_count: runs=%0d pass=%b want 5/1", bus.run_count, bus.pass);
        end
    endtask

    task automatic test_reset_mid_run();
        int doneAt, doneCount;
        logic busyFirst, busyAtDone;
        int spurious;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(6);
        testsRun++;
        if ({bus.busy, bus.e1_o, bus.e0_o} !== 3'b110) begin
            testsFailed++;
            $display("[TB] FAIL mid_idx2_drive: busy,e1,e0=%b want 110", {bus.busy, bus.e1_o, bus.e0_o});
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        testsRun++;
        if ({bus.e0_o, bus.e1_o, bus.busy, bus.done, bus.pass, bus.fail_valid,
             bus.fail_mask, bus.first_fail_vec, bus.run_count} !== 24'h0) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_outputs: busy=%b done=%b mask=%h runs=%0d want all 0",
                     bus.busy, bus.done, bus.fail_mask, bus.run_count);
        end
        spurious = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.done || bus.busy) spurious++;
            step(1);
        end
        testsRun++;
        if (spurious !== 0) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_quiet: got %0d active cycles want 0", spurious);
        end
        launchAndWatch(doneAt, doneCount, busyFirst, busyAtDone);
        testsRun++;
        if (doneAt !== 13 || bus.pass !== 1'b1 || bus.run_count !== 8'd1) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset_rerun: at=%0d pass=%b runs=%0d want 13/1/1",
                     doneAt, bus.pass, bus.run_count);
        end
    endtask

    task automatic test_back_to_back();
        int pulses, lastAt, badGaps;
        logic [7:0] countAt100;
        pulses     = 0;
        lastAt     = -1;
        badGaps    = 0;
        countAt100 = 8'h00;
        bus.start  = 1'b1;
        step(1);
        for (int off = 1; off <= 300 * 14 + 40 && pulses < 300; off++) begin
            if (bus.done) begin
                pulses++;
                if (lastAt < 0) begin
                    if (off != 13) badGaps++;
                end else if (off - lastAt != 14) begin
                    badGaps++;
                end
                lastAt = off;
                if (pulses == 100) countAt100 = bus.run_count;
                if (pulses == 300) bus.start = 1'b0;
            end
            step(1);
        end
        bus.start = 1'b0;
        testsRun++;
        if (pulses !== 300 || badGaps !== 0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_pulses: pulses=%0d badGaps=%0d want 300/0", pulses, badGaps);
        end
        testsRun++;
        if (countAt100 !== 8'd101) begin
            testsFailed++;
            $display("[TB] FAIL b2b_count_mid: got %0d want 101", countAt100);
        end
        step(3);
        testsRun++;
        if (bus.run_count !== 8'd255 || bus.busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_saturate: runs=%0d busy=%b want 255/0", bus.run_count, bus.busy);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        clrMask     = 8'h00;
        setMask     = 8'h00;
        idx3Ff      = 1'b0;
        #1;
        test_reset();
        test_pass_run();
        test_vector_drive();
        test_xor_fault();
        test_idx3_fault();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
